avst_timing_adapter_gen: RTL and testbench
==========================================

Name: avst_timing_adapter_gen

Overview:
- Parametrised Avalon-ST timing adapter for the Nios system's streaming fabric.
- Decouples a source with ready latency IN_READY_LATENCY (0..3) from a sink with ready latency 0, using an internal first-word-fall-through FIFO.
- Data, channel, error and FIFO depth widths are generic.
- Exports fill level and a sticky overflow indication, so that protocol violations by the source are visible instead of silently corrupting data.

Parameters:
- DATA_W, 32, data bus width in bits (1..512)
- CHANNEL_W, 2, channel width (0 = no channel signal; port kept at width 1, ignored, out_channel driven 0)
- ERROR_W, 6, error width (0 handled as for CHANNEL_W)
- DEPTH, 8, FIFO entries; power of two, >= IN_READY_LATENCY+2
- IN_READY_LATENCY, 0, input-side ready latency in cycles (0..3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_ready  out  1  input ready; source may present a beat IN_READY_LATENCY cycles later
- in_valid  in  1  input beat valid
- in_data  in  DATA_W  input data
- in_channel  in  CHANNEL_W  input channel
- in_error  in  ERROR_W  input error
- in_startofpacket  in  1  SOP
- in_endofpacket  in  1  EOP
- out_ready  in  1  sink ready (latency 0)
- out_valid  out  1  output beat valid
- out_data  out  DATA_W  output data
- out_channel  out  CHANNEL_W  output channel
- out_error  out  ERROR_W  output error
- out_startofpacket  out  1  SOP
- out_endofpacket  out  1  EOP
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: a beat arrived while the FIFO was full
- overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync-released internally by upstream logic):
  - fill_level=0, out_valid=0, overflow=0, pointers=0.
  - in_ready=1 after reset (combinational from fill_level).
  - out_* payload is don't-care while out_valid=0; the bench must not check it.
- Payload: {data, channel, error, sop, eop}, concatenated MSB→LSB, width DATA_W+CHANNEL_W+ERROR_W+2.
- in_ready = (fill_level < DEPTH − IN_READY_LATENCY). Combinational from the registered fill_level; no dependency on out_ready.
- Push: in_valid=1 and (fill_level<DEPTH or pop this cycle). in_valid is qualified by the FIFO state only; the ready history is not consulted.
- Pop: out_valid=1 and out_ready=1.
- out_valid = (fill_level != 0). The head entry drives out_* directly (FWFT).
- Latency: a beat pushed into an empty FIFO at edge t is presented at out_* from t+1. There is no combinational bypass.
- Simultaneous push+pop: fill_level unchanged and both pointers advance. This is legal at full (write slot freed by the same-cycle read) and at empty (push only, since out_valid=0).
- Pointers: $clog2(DEPTH) bits, natural wrap-around. fill_level is tracked as a separate counter: +1 on push only, −1 on pop only.
- Overflow: in_valid=1, fill_level==DEPTH and no pop → beat dropped and overflow set next edge. FIFO contents are unaffected.
- overflow_clr has priority below a same-cycle set, so the flag stays 1.
- Reset mid-stream: all buffered beats are discarded and out_valid drops asynchronously. No partial-packet recovery.
- Packet markers are passed through untouched; no packet-level checking.

Optional Feature:
- Macro: AVST_TA_OVERFLOW_DETECT_EN.
- Defined: overflow logic as above, plus a 16-bit saturating drop counter. Counter is readable only through hierarchy (debug) and cleared by overflow_clr.
- Undefined: overflow tied 0, overflow_clr ignored, no counter flops. Overflowing beats are still dropped.

Decomposition:
- Package avst_ta_pkg holds:
  - function payload_w(DATA_W, CHANNEL_W, ERROR_W)
  - function fill_w(DEPTH) = $clog2(DEPTH+1)
  - localparam MAX_READY_LATENCY=3, checked by an elaboration assertion together with the DEPTH constraints
- One sub-module, avst_ta_fifo: generic FWFT synchronous FIFO (WIDTH, DEPTH) with push/pop, fill counter and full/empty. The top handles ready threshold, payload packing and overflow.

Test Plan:
- Latency 0, DEPTH=8, out_ready=1, 20 back-to-back beats data=0..19 → out_data 0..19 in order, first out_valid one cycle after first push, fill_level ≤1.
- IN_READY_LATENCY=2, DEPTH=8, out_ready=0, source obeys latency → in_ready falls when fill_level=6; exactly 8 beats stored, overflow=0; then out_ready=1 drains 8 beats in order.
- DEPTH=8 full, in_valid=1 with out_ready=1 same cycle → beat accepted, fill_level stays 8, no overflow.
- DEPTH=8 full, out_ready=0, in_valid=1 for 3 cycles → overflow=1 (drop counter=3 with macro), FIFO contents unchanged. overflow_clr pulse → overflow=0.
- Packet of 5 beats, channel=3, error=0x2A, SOP on beat 0 and EOP on beat 4, random out_ready → all fields reproduced bit-exact. Check the wrap-around of pointers over 3×DEPTH beats.
- reset_n asserted with fill_level=5 → out_valid=0 and fill_level=0 immediately. After release, in_ready=1 and the next beat is output first.

Source files
------------

// File: rtl/avst_ta_pkg.sv
// Shared sizing helpers and limits for the Avalon-ST timing adapter.
// Used by avst_ta_fifo and avst_timing_adapter_gen.
package avst_ta_pkg;

  localparam int MAX_READY_LATENCY = 3;

  function automatic int payload_w(
    input int data_w,
    input int channel_w,
    input int error_w
  );
    return data_w + channel_w + error_w + 2;
  endfunction

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit cfg_ok(
    input int depth,
    input int latency
  );
    bit pow2;
    pow2 = (depth > 0) && ((depth & (depth - 1)) == 0);
    return pow2 &&
           (latency >= 0) &&
           (latency <= MAX_READY_LATENCY) &&
           (depth >= latency + 2);
  endfunction

endpackage

// File: rtl/avst_ta_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// The head entry is visible on rd_data whenever empty is low.
module avst_ta_fifo
  import avst_ta_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wr_data,
  output logic [WIDTH-1:0]          rd_data,
  output logic [fill_w(DEPTH)-1:0]  count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = fill_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A push at full is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage array; contents need no reset since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy counter, unchanged on simultaneous push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign full    = (cnt == FW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/avst_timing_adapter_gen.sv
// Avalon-ST timing adapter: source ready latency N to sink latency 0.
// Optional overflow flag and drop counter: AVST_TA_OVERFLOW_DETECT_EN.
module avst_timing_adapter_gen
  import avst_ta_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int CHANNEL_W        = 2,
  parameter int ERROR_W          = 6,
  parameter int DEPTH            = 8,
  parameter int IN_READY_LATENCY = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  output logic                                  in_ready,
  input  logic                                  in_valid,
  input  logic [DATA_W-1:0]                     in_data,
  input  logic [(CHANNEL_W>0?CHANNEL_W:1)-1:0]  in_channel,
  input  logic [(ERROR_W>0?ERROR_W:1)-1:0]      in_error,
  input  logic                                  in_startofpacket,
  input  logic                                  in_endofpacket,
  input  logic                                  out_ready,
  output logic                                  out_valid,
  output logic [DATA_W-1:0]                     out_data,
  output logic [(CHANNEL_W>0?CHANNEL_W:1)-1:0]  out_channel,
  output logic [(ERROR_W>0?ERROR_W:1)-1:0]      out_error,
  output logic                                  out_startofpacket,
  output logic                                  out_endofpacket,
  output logic [fill_w(DEPTH)-1:0]              fill_level,
  output logic                                  overflow,
  input  logic                                  overflow_clr
);

  localparam int PW = payload_w(DATA_W, CHANNEL_W, ERROR_W);
  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] RDY_THR =
    FW'(DEPTH - IN_READY_LATENCY);

  if (!cfg_ok(DEPTH, IN_READY_LATENCY) ||
      DATA_W < 1 || DATA_W > 512 ||
      CHANNEL_W < 0 || ERROR_W < 0) begin : g_bad_cfg
    $error("avst_timing_adapter_gen: bad parameters");
  end

  logic [PW-1:0] wr_pl;
  logic [PW-1:0] rd_pl;
  logic          pop;
  logic          full;
  logic          empty;

  // Pack {data, channel, error, sop, eop}; absent fields take no bits.
  if (CHANNEL_W > 0 && ERROR_W > 0) begin : g_pack_ce
    assign wr_pl = {in_data, in_channel, in_error,
                    in_startofpacket, in_endofpacket};
  end else if (CHANNEL_W > 0) begin : g_pack_c
    assign wr_pl = {in_data, in_channel,
                    in_startofpacket, in_endofpacket};
  end else if (ERROR_W > 0) begin : g_pack_e
    assign wr_pl = {in_data, in_error,
                    in_startofpacket, in_endofpacket};
  end else begin : g_pack_d
    assign wr_pl = {in_data,
                    in_startofpacket, in_endofpacket};
  end

  assign pop = out_valid & out_ready;

  avst_ta_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (wr_pl),
    .rd_data (rd_pl),
    .count   (fill_level),
    .full    (full),
    .empty   (empty)
  );

  // Threshold leaves room for beats still in flight from the source.
  assign in_ready  = (fill_level < RDY_THR);
  assign out_valid = ~empty;

  // Unpack the head entry onto the sink side.
  assign out_data          = rd_pl[PW-1 -: DATA_W];
  assign out_startofpacket = rd_pl[1];
  assign out_endofpacket   = rd_pl[0];

  if (CHANNEL_W > 0) begin : g_ch
    assign out_channel = rd_pl[CHANNEL_W+ERROR_W+1 -: CHANNEL_W];
  end else begin : g_no_ch
    assign out_channel = '0;
  end

  if (ERROR_W > 0) begin : g_err
    assign out_error = rd_pl[ERROR_W+1 -: ERROR_W];
  end else begin : g_no_err
    assign out_error = '0;
  end

`ifdef AVST_TA_OVERFLOW_DETECT_EN
  logic        drop;
  logic        ovf_q;
  logic [15:0] drop_cnt;

  assign drop = in_valid & full & ~pop;

  // Sticky flag; a same-cycle drop wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (overflow_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Saturating count of dropped beats, for debug visibility.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (overflow_clr) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (overflow_clr) begin
      drop_cnt <= '0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = overflow_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_avst_timing_adapter_gen.sv
// Scoreboard bench for avst_timing_adapter_gen.
// Reference model tracks occupancy and expected beats as a queue.
module tb_avst_timing_adapter_gen;

  localparam int DW    = 32;
  localparam int CW    = 2;
  localparam int EW    = 6;
  localparam int DEPTH = 8;
  localparam int IRL   = 2;
  localparam int PW    = DW + CW + EW + 2;

  logic          clk;
  logic          reset_n;
  logic          in_ready;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_channel;
  logic [EW-1:0] in_error;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_channel;
  logic [EW-1:0] out_error;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [3:0]    fill_level;
  logic          overflow;
  logic          overflow_clr;

  avst_timing_adapter_gen #(
    .DATA_W           (DW),
    .CHANNEL_W        (CW),
    .ERROR_W          (EW),
    .DEPTH            (DEPTH),
    .IN_READY_LATENCY (IRL)
  ) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_error          (in_error),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_error         (out_error),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .fill_level        (fill_level),
    .overflow          (overflow),
    .overflow_clr      (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [PW-1:0] exp_q [$];
  int            mfill;
  bit            movf;
  bit            rh [4];

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from occupancy rules only.
  always @(negedge clk or negedge reset_n) begin : model
    bit pop;
    bit push;
    bit drop;
    if (!reset_n) begin
      mfill = 0;
      movf  = 1'b0;
      exp_q.delete();
    end else begin
      chk("fill_level", 64'(fill_level), 64'(mfill));
      chk("out_valid", 64'(out_valid), 64'(mfill > 0));
      chk("in_ready", 64'(in_ready), 64'(mfill < DEPTH - IRL));
      chk("overflow", 64'(overflow), 64'(movf));
      pop  = (mfill > 0) && out_ready;
      push = in_valid && ((mfill < DEPTH) || pop);
      drop = in_valid && (mfill == DEPTH) && !pop;
      if (push)
        exp_q.push_back({in_data, in_channel, in_error,
                         in_startofpacket, in_endofpacket});
      mfill = mfill + int'(push) - int'(pop);
`ifdef AVST_TA_OVERFLOW_DETECT_EN
      if (drop) movf = 1'b1;
      else if (overflow_clr) movf = 1'b0;
`else
      if (drop) movf = 1'b0;
`endif
    end
  end

  // Monitor: every beat taken by the sink must match the queue head.
  always @(negedge clk) begin : monitor
    logic [PW-1:0] e;
    if (reset_n && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat: unexpected output %0h @%0t",
                 out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("payload",
            64'({out_data, out_channel, out_error,
                 out_startofpacket, out_endofpacket}),
            64'(e));
      end
    end
  end

  // One cycle of stimulus; obey restricts beats to the ready latency.
  task automatic step(
    input  bit          want,
    input  bit          obey,
    input  logic [31:0] d,
    input  logic [1:0]  c,
    input  logic [5:0]  e,
    input  bit          s,
    input  bit          eo,
    input  bit          ordy,
    input  bit          clr,
    output bit          sent
  );
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) rh[i] = rh[i-1];
    rh[0] = in_ready;
    sent = want && (!obey || rh[IRL]);
    in_valid         = sent;
    in_data          = d;
    in_channel       = c;
    in_error         = e;
    in_startofpacket = s;
    in_endofpacket   = eo;
    out_ready        = ordy;
    overflow_clr     = clr;
  endtask

  task automatic idle(input bit ordy, input int n);
    bit s;
    for (int i = 0; i < n; i++)
      step(0, 1, $urandom, 2'($urandom), 6'($urandom),
           0, 0, ordy, 0, s);
  endtask

  // Offer beats data=base.. until cnt sent or the cycle budget runs out.
  task automatic offer(
    input  int          base,
    input  int          cnt,
    input  bit          ordy,
    input  int          budget,
    output int          n
  );
    bit s;
    n = 0;
    for (int i = 0; i < budget && n < cnt; i++) begin
      step(1, 1, 32'(base + n), 2'd1, 6'd0, 0, 0, ordy, 0, s);
      if (s) n++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    bit s;
    vectors          = 0;
    miscompares      = 0;
    reset_n          = 1'b0;
    in_valid         = 1'b0;
    in_data          = '0;
    in_channel       = '0;
    in_error         = '0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    out_ready        = 1'b0;
    overflow_clr     = 1'b0;
    for (int i = 0; i < 4; i++) rh[i] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Back-to-back beats with an always-ready sink.
    offer(0, 20, 1'b1, 100, n);
    chk("t1_sent", 64'(n), 64'd20);
    idle(1, 4);

    // Sink stalled: latency-obeying source fills exactly DEPTH.
    offer(100, 20, 1'b0, 16, n);
    chk("t2_sent", 64'(n), 64'd8);
    @(negedge clk);
    chk("t2_fill", 64'(fill_level), 64'd8);
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    idle(1, 12);

    // Full FIFO with same-cycle push and pop.
    offer(200, 8, 1'b0, 16, n);
    idle(0, 2);
    step(1, 0, 32'h0000_0AAA, 2'd2, 6'd5, 0, 0, 1, 0, s);
    idle(0, 1);
    @(negedge clk);
    chk("t3_fill", 64'(fill_level), 64'd8);

    // Beats offered at full with a stalled sink are dropped.
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'hDEAD_0000 + 32'(i), 2'd0, 6'd0,
           0, 0, 0, 0, s);
    idle(0, 1);
    @(negedge clk);
    chk("t4_fill", 64'(fill_level), 64'd8);
`ifdef AVST_TA_OVERFLOW_DETECT_EN
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_drop_cnt", 64'(u_dut.drop_cnt), 64'd3);
`endif
    step(0, 1, '0, '0, '0, 0, 0, 0, 1, s);
    idle(0, 1);
    @(negedge clk);
    chk("t4_cleared", 64'(overflow), 64'd0);
    idle(1, 12);

    // Packet with fixed channel/error and a random sink.
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      step(1, 1, 32'hC0DE_0000 + 32'(n), 2'd3, 6'h2A,
           n == 0, n == 4, 1'($urandom_range(0, 1)), 0, s);
      if (s) n++;
    end
    chk("t5_pkt_sent", 64'(n), 64'd5);

    // Random traffic spanning several pointer wraps.
    n = 0;
    for (int i = 0; i < 600 && n < 5 * DEPTH; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1, $urandom,
           2'($urandom), 6'($urandom),
           1'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 0, s);
      if (s) n++;
    end
    chk("t5_rand_sent", 64'(n), 64'(5 * DEPTH));
    idle(1, 12);

    // Reset mid-stream with five beats buffered.
    offer(300, 5, 1'b0, 20, n);
    idle(0, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_fill", 64'(fill_level), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) rh[i] = 1'b1;
    step(1, 1, 32'h0000_5EED, 2'd1, 6'd9, 1, 1, 1, 0, s);
    chk("t6_sent", 64'(s), 64'd1);
    idle(1, 4);

    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
